// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
// Imported by the counter and the top level.
package clk_div_pkg;

  localparam int DIV_MIN = 2;

  function automatic int cnt_width(int div);
    return (div < DIV_MIN) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-N up-counter for the clock divider.
// Flags the half-period and wrap counts of the current value.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int DIV   = 6,
  parameter int CNT_W = cnt_width(DIV),
  parameter int HALF  = DIV / 2 - 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             half_hit,
  output logic             wrap_hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(HALF);

  // Strobes describe the count before the coming rising edge.
  always_comb begin
    half_hit = (cnt == MID);
    wrap_hit = (cnt == LAST);
  end

  // Count 0..DIV-1 and wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_6.sv
// Glitch-free 50% duty clock divider, divide-by-6 by default.
// Odd ratios add a falling-edge copy to stretch the high half.
module clk_div_6
  import clk_div_pkg::*;
#(
  parameter int DIV_RATIO = 6,
  parameter int CNT_W     = cnt_width(DIV_RATIO)
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  localparam bit IS_ODD = (DIV_RATIO % 2) != 0;
  localparam int HALF   = IS_ODD ? (DIV_RATIO - 1) / 2
                                 : DIV_RATIO / 2 - 1;

  logic [CNT_W-1:0] cnt;
  logic             half_hit;
  logic             wrap_hit;

  clk_div_counter #(
    .DIV   (DIV_RATIO),
    .CNT_W (CNT_W),
    .HALF  (HALF)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .half_hit (half_hit),
    .wrap_hit (wrap_hit)
  );

  // The counter must never pass its wrap value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt <= CNT_W'(DIV_RATIO - 1));
    end
  end

  if (DIV_RATIO < DIV_MIN) begin : g_bad
    $error("clk_div_6: DIV_RATIO %0d below %0d",
           DIV_RATIO, DIV_MIN);
  end

  if (!IS_ODD) begin : g_even

    logic p;

    // Toggle at mid-period and at wrap.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p <= 1'b0;
      end else if (half_hit || wrap_hit) begin
        p <= ~p;
      end
    end

    assign clk_out = p;

  end else begin : g_odd

    logic p;
    logic n;

    // Rising-edge half: set at mid count, clear at wrap.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p <= 1'b0;
      end else if (wrap_hit) begin
        p <= 1'b0;
      end else if (half_hit) begin
        p <= 1'b1;
      end
    end

    // Half-cycle delayed copy extends the high phase.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        n <= 1'b0;
      end else begin
        n <= p;
      end
    end

    assign clk_out = p | n;

  end

endmodule

// File: tb/tb_clk_div_6.sv
// Self-checking bench for clk_div_6 at ratios 6, 2, 5 and 3.
// Expected output derives from edges counted since reset release.
module tb_clk_div_6;

  logic clk;
  logic rst;
  logic c6, c2, c5, c3;

  int tests;
  int fails;
  int k;
  longint last_rise6;
  bit have_rise6;
  logic prev6;
  longint last3;

  clk_div_6 u6 (.clk(clk), .rst(rst), .clk_out(c6));
  clk_div_6 #(.DIV_RATIO(2)) u2 (
    .clk(clk), .rst(rst), .clk_out(c2));
  clk_div_6 #(.DIV_RATIO(5)) u5 (
    .clk(clk), .rst(rst), .clk_out(c5));
  clk_div_6 #(.DIV_RATIO(3)) u3 (
    .clk(clk), .rst(rst), .clk_out(c3));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic model(int r, int kk, bit rise);
    int m;
    if (kk == 0) return 1'b0;
    m = kk % r;
    if (r % 2 == 0) return logic'(m >= r / 2);
    if (rise && m == 0) return 1'b1;
    return logic'(m >= (r + 1) / 2);
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0t obs=%0b exp=%0b",
             tag, $time, obs, exp);
    end
  endtask

  task automatic chk_n(string tag, longint obs, longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0t obs=%0d exp=%0d",
             tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(bit rise);
    chk("div6", c6, model(6, k, rise));
    chk("div2", c2, model(2, k, rise));
    chk("div5", c5, model(5, k, rise));
    chk("div3", c3, model(3, k, rise));
    chk_n("cnt6", longint'(u6.cnt), longint'(k % 6));
    if (c6 && !prev6) begin
      if (have_rise6)
        chk_n("per6", $time - last_rise6, 60);
      last_rise6 = $time;
      have_rise6 = 1'b1;
    end
    if (!c6 && prev6 && have_rise6)
      chk_n("high6", $time - last_rise6, 30);
    prev6 = c6;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    check_all(1'b1);
    @(negedge clk);
    #1;
    check_all(1'b0);
  endtask

  task automatic reset_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_all(1'b1);
      @(negedge clk);
      #1;
      check_all(1'b0);
    end
  endtask

  task automatic do_reset(int gap, int hold);
    #(gap);
    rst = 1'b1;
    k = 0;
    have_rise6 = 1'b0;
    #1;
    check_all(1'b0);
    reset_cycles(hold);
    #1;
    rst = 1'b0;
  endtask

  always @(c3) begin
    if (!rst && $time > 0) begin
      tests++;
      assert (($time - last3) >= 5) else begin
        fails++;
        $error("FAIL glitch3 t=%0t obs=%0d exp=>=5",
               $time, $time - last3);
      end
    end
    last3 = $time;
  end

  initial begin
    int guard;
    tests = 0;
    fails = 0;
    k = 0;
    prev6 = 1'b0;
    have_rise6 = 1'b0;
    last3 = 0;
    rst = 1'b1;
    #1;
    check_all(1'b0);
    #4;
    rst = 1'b0;

    for (int i = 0; i < 130; i++) tick();

    guard = 0;
    while (k % 6 != 4 && guard < 12) begin
      tick();
      guard++;
    end
    chk("mid_high6", c6, 1'b1);
    do_reset(2, 6);

    for (int i = 0; i < 20; i++) tick();

    for (int r = 0; r < 8; r++) begin
      do_reset(int'($urandom_range(1, 3)),
               int'($urandom_range(1, 8)));
      for (int i = 0; i < int'($urandom_range(5, 60)); i++)
        tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
